fetch_align: RTL

Instruction realignment buffer between instruction memory and the decoder in the RV32IC pipeline. It issues word-aligned fetches and buffers up to four 16-bit parcels. It extracts one 16-bit (compressed) or 32-bit instruction per cycle at any halfword-aligned PC, including 32-bit instructions that straddle a word boundary. It also handles control-flow redirects from the execute stage and discards stale memory responses.

---
 rtl/fetch_align.sv | 135 +++++++++++++
 1 files changed

// File: rtl/fetch_align.sv
// Instruction realignment buffer: word-aligned fetch in, one 16/32-bit
// instruction per cycle out at any halfword PC, with redirect and stale-response drop.
module fetch_align #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_is_c
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned PW    = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 3;

  logic [PW-1:0]   parcel_q [DEPTH];
  logic [PW-1:0]   parcel_d [DEPTH];
  logic [PW-1:0]   shifted  [DEPTH];
  logic [CW-1:0]   count_q, count_d;
  logic [XLEN-1:0] fetch_addr_q, fetch_addr_d;
  logic [XLEN-1:0] head_pc_q, head_pc_d;
  logic            outstanding_q, outstanding_d;
  logic            drop_q, drop_d;
  logic            skip_half_q, skip_half_d;

  logic            head_is_c;
  logic            fire_req;
  logic            resp;
  logic            consume;
  logic [1:0]      pop_n;
  logic [1:0]      push_n;
  logic [PW-1:0]   push0;
  logic [CW-1:0]   base;

  // Outputs are decoded from registered state only; redirect and reset mask them.
  always_comb begin
    head_is_c   = (parcel_q[0][1:0] != 2'b11);
    instr_valid = reset && !redirect &&
                  (head_is_c ? (count_q >= 3'd1) : (count_q >= 3'd2));
    instr       = head_is_c ? {16'h0000, parcel_q[0]} : {parcel_q[1], parcel_q[0]};
    instr_pc    = head_pc_q;
    instr_is_c  = head_is_c;
    imem_req    = reset && !redirect && !outstanding_q && (count_q <= 3'd2);
    imem_addr   = fetch_addr_q;
  end

  // Next-state: pop from the head, then append the response parcels behind the survivors.
  always_comb begin
    fire_req      = imem_req && imem_ready;
    resp          = imem_rvalid && outstanding_q;
    consume       = instr_valid && instr_ready;
    pop_n         = consume ? (head_is_c ? 2'd1 : 2'd2) : 2'd0;
    push_n        = (resp && !drop_q && !redirect) ? (skip_half_q ? 2'd1 : 2'd2) : 2'd0;
    push0         = skip_half_q ? imem_rdata[31:16] : imem_rdata[15:0];
    base          = count_q - CW'(pop_n);

    for (int unsigned i = 0; i < DEPTH; i++) shifted[i] = parcel_q[i];
    case (pop_n)
      2'd1: begin
        shifted[0] = parcel_q[1];
        shifted[1] = parcel_q[2];
        shifted[2] = parcel_q[3];
      end
      2'd2: begin
        shifted[0] = parcel_q[2];
        shifted[1] = parcel_q[3];
      end
      default: ;
    endcase

    for (int unsigned i = 0; i < DEPTH; i++) parcel_d[i] = shifted[i];
    count_d       = base + CW'(push_n);
    fetch_addr_d  = fetch_addr_q;
    head_pc_d     = head_pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    skip_half_d   = skip_half_q;

    // A request is only issued with count <= 2, so appended parcels always fit.
    if (push_n != 2'd0) parcel_d[base[1:0]] = push0;
    if (push_n == 2'd2) parcel_d[2'(base + 3'd1)] = imem_rdata[31:16];

    if (redirect) begin
      count_d       = '0;
      head_pc_d     = redirect_pc & ~32'd1;
      fetch_addr_d  = redirect_pc & ~32'd3;
      skip_half_d   = redirect_pc[1];
      drop_d        = outstanding_q && !imem_rvalid;
      outstanding_d = outstanding_q && !imem_rvalid;
    end else begin
      if (fire_req) begin
        outstanding_d = 1'b1;
        fetch_addr_d  = fetch_addr_q + 32'd4;
      end
      if (resp) begin
        outstanding_d = 1'b0;
        drop_d        = 1'b0;
        if (!drop_q) skip_half_d = 1'b0;
      end
      if (consume) head_pc_d = head_pc_q + (head_is_c ? 32'd2 : 32'd4);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) parcel_q[i] <= '0;
      count_q       <= '0;
      fetch_addr_q  <= RESET_PC & ~32'd3;
      head_pc_q     <= RESET_PC & ~32'd1;
      outstanding_q <= 1'b0;
      drop_q        <= 1'b0;
      skip_half_q   <= RESET_PC[1];
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) parcel_q[i] <= parcel_d[i];
      count_q       <= count_d;
      fetch_addr_q  <= fetch_addr_d;
      head_pc_q     <= head_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      skip_half_q   <= skip_half_d;
    end
  end

endmodule
